// File: rtl/calc_pkg.sv
// calc_pkg: shared arithmetic types, constants and reference function for the mini-calculator datapath.
package calc_pkg;
  localparam int ADDER_LATENCY = 1;
  typedef struct packed {
    logic carry;
    logic sum;
  } add_res_t;
  function automatic add_res_t full_add(input logic a, input logic b, input logic ci);
    return add_res_t'({1'b0, a} + {1'b0, b} + {1'b0, ci});
  endfunction
endpackage

// File: rtl/half_adder.sv
// half_adder: single-bit half adder, s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/one_bit_adder.sv
// one_bit_adder: full adder built from two half adders, with optional registered outputs.
module one_bit_adder
  import calc_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Sum,
  output logic Cout
);
  logic s0, c0, s1, c1;
  add_res_t res_d;
  half_adder u_ha0 (.a(A),  .b(B),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(Ci), .s(s1), .c(c1));
  always_comb begin
    res_d.carry = c0 | c1;
    res_d.sum   = s1;
  end
  generate
    if (REG_OUT) begin : g_reg
      add_res_t res_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
      end
      assign Cout = res_q.carry;
      assign Sum  = res_q.sum;
      a_rst_zero: assert property (@(posedge clk) !rst_n |-> {Cout, Sum} == 2'b00);
      a_add: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> {Cout, Sum} == full_add($past(A), $past(B), $past(Ci)));
      a_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({A, B, Ci}));
    end else begin : g_comb
      // clk/rst_n are intentionally ignored in the combinational variant
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign Cout = res_d.carry;
      assign Sum  = res_d.sum;
    end
  endgenerate
endmodule

// File: tb/tb_one_bit_adder.sv
// tb_one_bit_adder: scoreboard bench for registered, combinational and rippled one_bit_adder.
module tb_one_bit_adder;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic rst_n, a, b, ci, sum, cout;
  logic cclk, crst_n, ca, cb, cci, csum, ccout;
  logic [3:0] ra, rb, rs;
  logic [4:0] rc;
  logic [1:0] sb[$];
  logic [1:0] tbl[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  one_bit_adder #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Ci(ci), .Sum(sum), .Cout(cout)
  );
  one_bit_adder #(.REG_OUT(1'b0)) dut_c (
    .clk(cclk), .rst_n(crst_n), .A(ca), .B(cb), .Ci(cci), .Sum(csum), .Cout(ccout)
  );
  for (genvar g = 0; g < 4; g++) begin : g_rip
    one_bit_adder #(.REG_OUT(1'b0)) u_rip (
      .clk(cclk), .rst_n(crst_n), .A(ra[g]), .B(rb[g]), .Ci(rc[g]), .Sum(rs[g]), .Cout(rc[g+1])
    );
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [2:0] v);
    @(negedge clk);
    if (sb.size() != 0) chk(tag, {6'b0, cout, sum}, {6'b0, sb.pop_front()});
    {a, b, ci} = v;
    sb.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
  endtask
  task automatic flush(input string tag);
    @(negedge clk);
    while (sb.size() != 0) chk(tag, {6'b0, cout, sum}, {6'b0, sb.pop_front()});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; {a, b, ci} = 3'b111;
    cclk = 1'b0; crst_n = 1'b1; {ca, cb, cci} = 3'b000;
    ra = '0; rb = '0; rc[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", {6'b0, cout, sum}, 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {6'b0, cout, sum}, 8'h03);
    for (int i = 0; i < 8; i++) step("sweep", 3'(i));
    flush("sweep");
    for (int i = 0; i < 12; i++) step("toggle", i[0] ? 3'b000 : 3'b111);
    flush("toggle");
    @(negedge clk);
    {a, b, ci} = 3'b110;
    @(posedge clk);
    #1 chk("pre_rst", {6'b0, cout, sum}, 8'h02);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {6'b0, cout, sum}, 8'h00);
    @(posedge clk);
    #1 chk("rst_held", {6'b0, cout, sum}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; {a, b, ci} = 3'b001;
    @(posedge clk);
    #1 chk("post_rst", {6'b0, cout, sum}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      {ca, cb, cci} = 3'(i);
      crst_n = i[0];
      #1 chk("comb", {6'b0, ccout, csum}, {6'b0, tbl[i]});
      chk("pkg", {6'b0, full_add(ca, cb, cci)}, {6'b0, tbl[i]});
      #9;
    end
    ra = 4'b1111; rb = 4'b0001; rc[0] = 1'b0;
    #1 chk("ripple_sum", {4'b0, rs}, 8'h00);
    chk("ripple_cout", {7'b0, rc[4]}, 8'h01);
    ra = 4'b0101; rb = 4'b0011; rc[0] = 1'b1;
    #1 chk("ripple_sum", {4'b0, rs}, 8'h09);
    chk("ripple_cout", {7'b0, rc[4]}, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
